bus_uart: RTL
=============

Name: bus_uart

Overview:
- Memory-mapped serial port on the CPU6 external bus; consumes the CPU's `addressBus`, `dataOutBus` and `writeEnBus`.
- Returns read data for the top-level `dataInBus` mux.
- Function: 8N1 asynchronous serial TX with a small FIFO, RX with a single holding register, status register, optional interrupt request.
- Sits directly downstream of the CPU core, alongside the memory.

Parameters:
- BASE_ADDR, 16'hF200, base of the 4-byte register window; the low 2 address bits select the register.
- CLKS_PER_BIT, 16, clocks per serial bit; must be >= 4 and even.
- TX_DEPTH, 4, TX FIFO entries; must be a power of two, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- bus_address  in  16  CPU `addressBus`.
- bus_wdata  in  8  CPU `dataOutBus`.
- bus_write  in  1  CPU `writeEnBus`; one-cycle write strobe.
- bus_read  in  1  one-cycle read strobe (top level asserts it when the CPU samples `dataInBus`); pops RX.
- rdata  out  8  combinational read data for the selected register.
- selected  out  1  combinational; high when bus_address[15:2] == BASE_ADDR[15:2].
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous.
- irq  out  1  interrupt request, registered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - txd=1, irq=0.
  - FIFO empty, rx_full=0, all error bits 0, both FSMs IDLE, control register 0.
- Reset mid-frame aborts the frame; txd is 1 on the cycle after the reset edge.
- Register map (offset = bus_address[1:0]):
  - 0 STATUS, read: bit0 rx_full, bit1 tx_not_full, bit2 rx_overrun, bit3 framing_err, bit4 tx_overflow, bit5 tx_busy (FSM not IDLE or FIFO non-empty); others 0.
  - 0 STATUS, write: bit7=1 clears bits 2..4.
  - 1 DATA, write: push to TX FIFO.
  - 1 DATA, read: RX holding byte; a bus_read strobe clears rx_full at the edge.
  - 2 CONTROL: see the optional feature.
  - 3: reads 0, writes ignored.
- Writes take effect at the rising edge where bus_write and selected are both high.
- TX FIFO:
  - Push to a full FIFO is dropped and sets tx_overflow.
  - Simultaneous push and pop while full is accepted; count is unchanged.
  - Pointers wrap modulo TX_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop and go to START; txd=0 from the next edge. A write to an empty FIFO therefore gives txd low exactly 1 clock after the write edge.
  - Each bit holds for exactly CLKS_PER_BIT clocks.
  - DATA sends 8 bits, LSB first.
  - STOP drives txd=1 for one bit time. On STOP expiry, go to START directly if the FIFO is non-empty (back-to-back frames, no idle gap), else to IDLE.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge of the synced rxd goes to START.
  - START: wait CLKS_PER_BIT/2 clocks, then go to DATA if the line is still 0, else back to IDLE (glitch).
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: sample once. If 0, set framing_err and discard the byte. If 1, deliver the byte.
- RX delivery:
  - Delivery with rx_full=0 loads the holding register and sets rx_full.
  - Delivery with rx_full=1 sets rx_overrun; the old byte is kept and the new byte discarded.
  - Delivery in the same cycle as a popping bus_read: the new byte loads, rx_full stays 1, no overrun.
- Bus traffic never stalls; rdata is valid only while selected.

Optional Feature:
- Macro: BUS_UART_IRQ_EN.
- Defined:
  - CONTROL register: bit0 rx_ie, bit1 tx_ie; read/write.
  - irq is registered: (rx_ie & rx_full) | (tx_ie & FIFO empty & TX FSM IDLE).
  - irq updates one clock after its causing state.
- Undefined:
  - irq tied 0.
  - CONTROL reads 0 and writes are ignored.

Decomposition:
- Package bus_uart_pkg:
  - Register offset constants.
  - STATUS bit index constants.
  - tx_state_t and rx_state_t enums (IDLE, START, DATA, STOP).
- Sub-module bus_uart_fifo:
  - Parameterized depth and width.
  - Push/pop ports; full, empty and count outputs.
  - Simultaneous push/pop when full is legal.
- Top-level instantiates it for the TX path.

Test Plan (CLKS_PER_BIT=4, TX_DEPTH=4):
- Write 8'h55 to F201 after reset. Required: txd falls 1 clock later; bits 1,0,1,0,1,0,1,0 (LSB first); stop bit 1; each bit 4 clocks; total 40 clocks; then tx_busy=0.
- Five back-to-back writes 8'h01..8'h05 while the first is still sending. Required: 8'h05 accepted only if the first pop has occurred; otherwise tx_overflow=1. Frames are back-to-back with no idle gap between stop and start bits.
- Drive rxd with a 0xA3 frame at 4 clk/bit. Required: STATUS=8'h03 (rx_full, tx_not_full); reading F201 with bus_read returns 8'hA3, then STATUS bit0=0.
- Send two frames without reading. Required: first byte retained, rx_overrun=1. Write 8'h80 to F200: bit2 clears, bit0 stays 1.
- Frame with stop bit 0. Required: framing_err=1, rx_full=0. Separately, a 1-clock low glitch on rxd: no byte delivered.
- Assert reset mid-TX frame. Required: txd=1 and STATUS bit5=0 on the next cycle. With BUS_UART_IRQ_EN, write 8'h01 to F202, receive a byte: irq rises 1 clock after rx_full, falls after the read.

Source files
------------

// File: rtl/bus_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart_pkg
// Description : Shared constants and state types for the bus_uart serial port:
//               register offsets, STATUS bit positions, TX/RX FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_uart_pkg;

  // Register offsets within the 4-byte window (bus_address[1:0])
  localparam logic [1:0] c_REG_STATUS  = 2'd0;
  localparam logic [1:0] c_REG_DATA    = 2'd1;
  localparam logic [1:0] c_REG_CONTROL = 2'd2;
  localparam logic [1:0] c_REG_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int c_ST_RX_FULL     = 0;
  localparam int c_ST_TX_NOT_FULL = 1;
  localparam int c_ST_RX_OVERRUN  = 2;
  localparam int c_ST_FRAMING     = 3;
  localparam int c_ST_TX_OVERFLOW = 4;
  localparam int c_ST_TX_BUSY     = 5;
  // Writing a 1 here to STATUS clears the sticky error bits
  localparam int c_ST_CLEAR       = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart_fifo
// Description : Small synchronous FIFO with show-ahead read data. A push to a
//               full FIFO is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int                 c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]      c_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_uart.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart
// Description : Memory-mapped 8N1 UART for the CPU6 bus. TX through a small
//               FIFO, RX into a single holding register, sticky status bits.
//               Optional interrupt logic enabled by macro BUS_UART_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic [7:0]  rdata,
  output logic        selected,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int               c_CW        = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0]  c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0]  c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);

  // Bus decode
  logic [1:0] w_offset;
  logic       w_wr_status, w_push, w_rd_pop;
  assign selected    = (bus_address[15:2] == BASE_ADDR[15:2]);
  assign w_offset    = bus_address[1:0];
  assign w_wr_status = bus_write && selected && (w_offset == c_REG_STATUS);
  assign w_push      = bus_write && selected && (w_offset == c_REG_DATA);
  assign w_rd_pop    = bus_read  && selected && (w_offset == c_REG_DATA);

  // TX FIFO
  logic [7:0]                  w_fifo_dout;
  logic                        w_fifo_full, w_fifo_empty, w_tx_pop;
  logic [$clog2(TX_DEPTH):0]   w_fifo_count;

  bus_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (bus_wdata),
    .i_pop   (w_tx_pop),
    .o_rdata (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // ---------------- TX path ----------------
  tx_state_t       r_tx_state, w_tx_state_nx;
  logic [c_CW-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]      r_tx_bit, w_tx_bit_nx;
  logic [7:0]      r_tx_shift, w_tx_shift_nx;
  logic            r_txd, w_txd_nx;

  // TX state register; txd is registered so it idles high straight out of reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_txd      <= w_txd_nx;
    end
  end

  // TX next state: pop on IDLE or at STOP expiry so frames run back-to-back
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt + 1'b1;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_pop      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        if (!w_fifo_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_shift_nx = w_fifo_dout;
          w_tx_state_nx = TX_START;
        end
      end
      TX_START: if (r_tx_cnt == c_BIT_LAST) begin
        w_tx_cnt_nx   = '0;
        w_tx_bit_nx   = '0;
        w_tx_state_nx = TX_DATA;
      end
      TX_DATA: if (r_tx_cnt == c_BIT_LAST) begin
        w_tx_cnt_nx   = '0;
        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
        if (r_tx_bit == 3'd7) w_tx_state_nx = TX_STOP;
        else                  w_tx_bit_nx   = r_tx_bit + 3'd1;
      end
      TX_STOP: if (r_tx_cnt == c_BIT_LAST) begin
        w_tx_cnt_nx = '0;
        if (!w_fifo_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_shift_nx = w_fifo_dout;
          w_tx_state_nx = TX_START;
        end else begin
          w_tx_state_nx = TX_IDLE;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
    case (w_tx_state_nx)
      TX_START: w_txd_nx = 1'b0;
      TX_DATA:  w_txd_nx = w_tx_shift_nx[0];
      default:  w_txd_nx = 1'b1;
    endcase
  end

  assign txd = r_txd;

  // ---------------- RX path ----------------
  logic [1:0]      r_rx_sync;
  logic            r_rx_prev, w_rx;
  rx_state_t       r_rx_state, w_rx_state_nx;
  logic [c_CW-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]      r_rx_bit, w_rx_bit_nx;
  logic [7:0]      r_rx_shift, w_rx_shift_nx;
  logic            w_deliver, w_frame_err;

  assign w_rx = r_rx_sync[1];

  // RX synchronizer, edge history and FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rxd};
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // RX next state: half-bit start qualification, then mid-bit sampling
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt + 1'b1;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_deliver     = 1'b0;
    w_frame_err   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = '0;
        if (!w_rx && r_rx_prev) w_rx_state_nx = RX_START;
      end
      RX_START: if (r_rx_cnt == c_HALF_LAST) begin
        w_rx_cnt_nx   = '0;
        w_rx_bit_nx   = '0;
        w_rx_state_nx = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == c_BIT_LAST) begin
        w_rx_cnt_nx   = '0;
        w_rx_shift_nx = {w_rx, r_rx_shift[7:1]};
        if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
        else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
      end
      RX_STOP: if (r_rx_cnt == c_BIT_LAST) begin
        w_rx_cnt_nx   = '0;
        w_rx_state_nx = RX_IDLE;
        w_deliver     = w_rx;
        w_frame_err   = !w_rx;
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- Status / holding register ----------------
  logic       r_rx_full, r_rx_overrun, r_framing, r_tx_overflow;
  logic [7:0] r_rx_hold;

  // Sticky flags: a status clear is overridden by a same-cycle set
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_full     <= 1'b0;
      r_rx_hold     <= '0;
      r_rx_overrun  <= 1'b0;
      r_framing     <= 1'b0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_wr_status && bus_wdata[c_ST_CLEAR]) begin
        r_rx_overrun  <= 1'b0;
        r_framing     <= 1'b0;
        r_tx_overflow <= 1'b0;
      end
      if (w_push && w_fifo_full && !w_tx_pop) r_tx_overflow <= 1'b1;
      if (w_frame_err) r_framing <= 1'b1;
      if (w_deliver) begin
        if (!r_rx_full || w_rd_pop) begin
          r_rx_hold <= r_rx_shift;
          r_rx_full <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (w_rd_pop) begin
        r_rx_full <= 1'b0;
      end
    end
  end

  // ---------------- Control / interrupt ----------------
  logic [7:0] w_ctrl_rd;
`ifdef BUS_UART_IRQ_EN
  logic [1:0] r_ctrl;
  logic       r_irq;

  // CONTROL register and registered interrupt request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (bus_write && selected && (w_offset == c_REG_CONTROL)) r_ctrl <= bus_wdata[1:0];
      r_irq <= (r_ctrl[0] && r_rx_full) ||
               (r_ctrl[1] && w_fifo_empty && (r_tx_state == TX_IDLE));
    end
  end
  assign w_ctrl_rd = {6'b0, r_ctrl};
  assign irq       = r_irq;
`else
  assign w_ctrl_rd = 8'h00;
  assign irq       = 1'b0;
`endif

  // Read-data mux for the selected register
  always_comb begin
    rdata = '0;
    case (w_offset)
      c_REG_STATUS: begin
        rdata[c_ST_RX_FULL]     = r_rx_full;
        rdata[c_ST_TX_NOT_FULL] = !w_fifo_full;
        rdata[c_ST_RX_OVERRUN]  = r_rx_overrun;
        rdata[c_ST_FRAMING]     = r_framing;
        rdata[c_ST_TX_OVERFLOW] = r_tx_overflow;
        rdata[c_ST_TX_BUSY]     = (r_tx_state != TX_IDLE) || (w_fifo_count != '0);
      end
      c_REG_DATA:    rdata = r_rx_hold;
      c_REG_CONTROL: rdata = w_ctrl_rd;
      c_REG_RSVD:    rdata = '0;
      default:       rdata = '0;
    endcase
  end

endmodule
`default_nettype wire
